alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 32-bit ALU between two requesters (port 0: core datapath, port 1: auxiliary
//  unit, e.g. address generation). Round-robin arbitration, valid/ready request channels,
//  one outstanding operation, result returned on the winner's response channel with backpressure.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width
//  OPCODE_LENGTH  4   ALU operation code width
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               synchronous, active-high
//  req_valid    in   2               request valid, bit i = port i
//  req_ready    out  2               request accepted when valid&ready
//  req_srca     in   2*DATA_WIDTH    operand A, [i*W +: W] = port i
//  req_srcb     in   2*DATA_WIDTH    operand B, per port
//  req_op       in   2*OPCODE_LENGTH ALU operation, per port
//  rsp_valid    out  2               response valid, one-hot or zero
//  rsp_ready    in   2               requester accepts response
//  rsp_result   out  DATA_WIDTH      ALU result (shared bus, qualified by rsp_valid)
//  rsp_err      out  1               op was not a defined ALU encoding (result is 0)
//  busy         out  1               FSM not in IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, rr_last=1 (port 0 wins first tie), req_ready=0, rsp_valid=0,
//    rsp_result=0, rsp_err=0, busy=0. Reset mid-operation drops the in-flight op; no response.
//  - FSM: IDLE -> EXEC on accept; EXEC -> RESP unconditionally; RESP -> IDLE when
//    rsp_valid[owner] & rsp_ready[owner]; otherwise RESP holds result/err/owner stable.
//  - IDLE: req_ready is one-hot grant (combinational from req_valid, rr_last); zero in EXEC/RESP.
//    One valid -> that port granted. Both valid -> port != rr_last granted. None -> 0.
//  - Accept (cycle N): latch srca, srcb, op, owner; rr_last<=owner.
//  - EXEC (N+1): latched operands drive ALU; result and err registered at clock edge.
//  - RESP: rsp_valid[owner]=1 from cycle N+2. Minimum accept-to-accept interval 3 cycles.
//  - Ops (ALU encoding): AND 0000, OR 0001, ADD 0010, SLTI 0011, XOR 0101, SUB 0110, SLT 0111,
//    EQ 1000, ADDI 1100. ADD/ADDI/SUB wrap mod 2^DATA_WIDTH. SLT/SLTI unsigned compare, result 0/1.
//    Any other code: result 0, rsp_err=1.
//  - Request payload not latched unless accepted; requester holds valid/payload until ready.
//  - Response on one port never blocks on the other port's rsp_ready.
// STRUCTURE
//  - Package alu_pkg: alu_op_t enum (codes above), arb_state_t {IDLE, EXEC, RESP},
//    function is_legal_op(alu_op_t).
//  - Sub-module: existing alu instance, fed from operand registers. Arbiter, FSM and response
//    registers stay in this module.
// TESTING
//  1 Single req port0: A=5,B=7,op=0010 at N -> rsp_valid=2'b01 at N+2, result=12, err=0.
//  2 Both valid after reset, port0 SUB 10-3, port1 XOR F0^0F -> port0 first (7), then port1 (FF).
//    Both held valid continuously -> grants strictly alternate 0,1,0,1.
//  3 Backpressure: port1 rsp_ready=0 for 5 cycles -> rsp_valid/result held, req_ready=0 throughout.
//  4 Illegal op 4'b1111 on port0 -> result 0, rsp_err=1; next legal op clears err.
//  5 Edge arithmetic: ADD FFFFFFFF+1 -> 0; SLT 1<FFFFFFFF -> 1; EQ 3==3 -> 1.
//  6 Reset asserted in EXEC -> next cycle IDLE, rsp_valid=0, no response emitted, port0 wins next tie.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: operation encodings, arbiter FSM states,
// and a legality check for incoming opcodes.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLTI = 4'b0011,
      OP_XOR  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_EQ   = 4'b1000,
      OP_ADDI = 4'b1100
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } arb_state_t;

   function automatic logic is_legal_op(alu_op_t op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SLTI, OP_XOR,
         OP_SUB, OP_SLT, OP_EQ, OP_ADDI: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Compares are unsigned and add/sub wrap.
// Any code outside the defined set produces a zero result.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic [DATA_WIDTH-1:0]    srca,
   input  logic [DATA_WIDTH-1:0]    srcb,
   input  logic [OPCODE_LENGTH-1:0] op,
   output logic [DATA_WIDTH-1:0]    result
);

   always_comb begin
      result = '0;
      case (op)
         OP_AND:          result = srca & srcb;
         OP_OR:           result = srca | srcb;
         OP_ADD, OP_ADDI: result = srca + srcb;
         OP_XOR:          result = srca ^ srcb;
         OP_SUB:          result = srca - srcb;
         OP_SLT, OP_SLTI: result = {{(DATA_WIDTH-1){1'b0}}, (srca < srcb)};
         OP_EQ:           result = {{(DATA_WIDTH-1){1'b0}}, (srca == srcb)};
         default:         result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters; one op in flight,
// result returned on the winner's response channel and held until it is taken.
//
// state | meaning
// IDLE  | no op in flight; req_ready carries the one-hot grant
// EXEC  | latched operands drive the ALU; result/err captured at end of cycle
// RESP  | rsp_valid[owner] high, result/err/owner held until rsp_ready[owner]
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [2*DATA_WIDTH-1:0]    req_srca,
   input  logic [2*DATA_WIDTH-1:0]    req_srcb,
   input  logic [2*OPCODE_LENGTH-1:0] req_op,
   output logic [1:0]                 rsp_valid,
   input  logic [1:0]                 rsp_ready,
   output logic [DATA_WIDTH-1:0]      rsp_result,
   output logic                       rsp_err,
   output logic                       busy
);

   arb_state_t                state_q, state_d;
   logic                      rr_last_q, rr_last_d;
   logic                      owner_q, owner_d;
   logic [DATA_WIDTH-1:0]     srca_q, srca_d;
   logic [DATA_WIDTH-1:0]     srcb_q, srcb_d;
   logic [OPCODE_LENGTH-1:0]  op_q, op_d;
   logic [DATA_WIDTH-1:0]     result_q, result_d;
   logic                      err_q, err_d;

   logic [1:0]                grant;
   logic [DATA_WIDTH-1:0]     alu_result;

   alu #(
      .DATA_WIDTH    (DATA_WIDTH),
      .OPCODE_LENGTH (OPCODE_LENGTH)
   ) u_alu (
      .srca   (srca_q),
      .srcb   (srcb_q),
      .op     (op_q),
      .result (alu_result)
   );

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      grant = 2'b00;
      if (state_q == IDLE) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      owner_d   = owner_q;
      srca_d    = srca_q;
      srcb_d    = srcb_q;
      op_d      = op_q;
      result_d  = result_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               state_d   = EXEC;
               owner_d   = grant[1];
               rr_last_d = grant[1];
               srca_d    = grant[1] ? req_srca[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : req_srca[DATA_WIDTH-1:0];
               srcb_d    = grant[1] ? req_srcb[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : req_srcb[DATA_WIDTH-1:0];
               op_d      = grant[1] ? req_op[2*OPCODE_LENGTH-1:OPCODE_LENGTH]
                                    : req_op[OPCODE_LENGTH-1:0];
            end
         end
         EXEC: begin
            state_d  = RESP;
            result_d = alu_result;
            err_d    = ~is_legal_op(alu_op_t'(op_q));
         end
         RESP: begin
            if (rsp_ready[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
         owner_q   <= 1'b0;
         srca_q    <= '0;
         srcb_q    <= '0;
         op_q      <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         owner_q   <= owner_d;
         srca_q    <= srca_d;
         srcb_q    <= srcb_d;
         op_q      <= op_d;
         result_q  <= result_d;
         err_q     <= err_d;
      end
   end

   assign req_ready  = grant;
   assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-port ops with hand-computed results,
// plus sequences for round-robin alternation, response backpressure and mid-op reset.
module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_srca;
   logic [63:0] req_srcb;
   logic [7:0]  req_op;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_srca   (req_srca),
      .req_srcb   (req_srcb),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          port;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        err;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_port(input int port, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
      req_srca[port*32 +: 32] = a;
      req_srcb[port*32 +: 32] = b;
      req_op[port*4 +: 4]     = op;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Issue one op on a single port and check the response arrives exactly two cycles after accept.
   task automatic run_op(input int idx);
      int n;
      logic [1:0] exp_v;
      exp_v = (vecs[idx].port == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      rsp_ready = 2'b11;
      set_port(vecs[idx].port, vecs[idx].a, vecs[idx].b, vecs[idx].op);
      req_valid = exp_v;
      n = 0;
      #1;
      while (!req_ready[vecs[idx].port] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk($sformatf("v%0d_accept", idx), (n < 20) ? 32'd1 : 32'd0, 32'd1);
      if (n < 20) begin
         @(negedge clk);
         req_valid = 2'b00;
         #1;
         chk($sformatf("v%0d_exec_rsp_valid", idx), rsp_valid, 2'b00);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, exp_v);
         chk($sformatf("v%0d_result", idx), rsp_result, vecs[idx].res);
         chk($sformatf("v%0d_err", idx), rsp_err, vecs[idx].err);
      end
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_idle", idx), busy, 1'b0);
   endtask

   initial begin
      int n;
      int got;
      int rsp_port[4];
      logic [31:0] rsp_res[4];

      vecs[0]  = '{0, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0};
      vecs[1]  = '{1, 32'h0000_00F0,  32'h0000_000F,  4'b0101, 32'h0000_00FF,  1'b0};
      vecs[2]  = '{0, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b0};
      vecs[3]  = '{1, 32'd1,          32'hFFFF_FFFF,  4'b0111, 32'd1,          1'b0};
      vecs[4]  = '{0, 32'd3,          32'd3,          4'b1000, 32'd1,          1'b0};
      vecs[5]  = '{0, 32'd3,          32'd4,          4'b1000, 32'd0,          1'b0};
      vecs[6]  = '{0, 32'd10,         32'd3,          4'b0110, 32'd7,          1'b0};
      vecs[7]  = '{1, 32'd0,          32'd1,          4'b0110, 32'hFFFF_FFFF,  1'b0};
      vecs[8]  = '{0, 32'h0000_F0F0,  32'h0000_FF00,  4'b0000, 32'h0000_F000,  1'b0};
      vecs[9]  = '{1, 32'h0000_F0F0,  32'h0000_0F00,  4'b0001, 32'h0000_FFF0,  1'b0};
      vecs[10] = '{0, 32'd5,          32'd5,          4'b0011, 32'd0,          1'b0};
      vecs[11] = '{0, 32'd4,          32'd5,          4'b0011, 32'd1,          1'b0};
      vecs[12] = '{1, 32'h7FFF_FFFF,  32'd1,          4'b1100, 32'h8000_0000,  1'b0};
      vecs[13] = '{0, 32'd1,          32'd2,          4'b1111, 32'd0,          1'b1};
      vecs[14] = '{0, 32'd1,          32'd2,          4'b0010, 32'd3,          1'b0};
      vecs[15] = '{1, 32'd1,          32'd2,          4'b0100, 32'd0,          1'b1};
      vecs[16] = '{1, 32'd9,          32'd9,          4'b0000, 32'd9,          1'b0};

      reset     = 1'b1;
      req_valid = 2'b00;
      req_srca  = '0;
      req_srcb  = '0;
      req_op    = '0;
      rsp_ready = 2'b11;
      do_reset();
      #1;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_busy", busy, 1'b0);

      for (int i = 0; i < 17; i++) run_op(i);

      // Both ports held valid from reset: grants alternate starting with port 0.
      do_reset();
      @(negedge clk);
      set_port(0, 32'd10, 32'd3, 4'b0110);
      set_port(1, 32'h0000_00F0, 32'h0000_000F, 4'b0101);
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      #1;
      chk("rr_first_grant", req_ready, 2'b01);
      got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         @(negedge clk);
         #1;
         if (rsp_valid != 2'b00) begin
            rsp_port[got] = rsp_valid[1] ? 1 : 0;
            rsp_res[got]  = rsp_result;
            chk($sformatf("rr%0d_onehot", got), {30'd0, rsp_valid},
                rsp_valid[1] ? 32'd2 : 32'd1);
            got++;
         end
      end
      req_valid = 2'b00;
      chk("rr_count", got, 4);
      for (int k = 0; k < got; k++) begin
         chk($sformatf("rr%0d_port", k), rsp_port[k], k % 2);
         chk($sformatf("rr%0d_result", k), rsp_res[k], (k % 2 == 0) ? 32'd7 : 32'hFF);
      end

      // Port 1 holds off its response; port 0's rsp_ready must not release it.
      do_reset();
      @(negedge clk);
      set_port(1, 32'd100, 32'd23, 4'b0010);
      set_port(0, 32'd1, 32'd1, 4'b0010);
      rsp_ready = 2'b01;
      req_valid = 2'b10;
      n = 0;
      #1;
      while (!rsp_valid[1] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("bp_rsp_seen", (n < 20) ? 32'd1 : 32'd0, 32'd1);
      req_valid = 2'b11;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("bp%0d_rsp_valid", c), rsp_valid, 2'b10);
         chk($sformatf("bp%0d_result", c), rsp_result, 32'd123);
         chk($sformatf("bp%0d_req_ready", c), req_ready, 2'b00);
      end
      rsp_ready = 2'b10;
      @(negedge clk);
      #1;
      chk("bp_release_rsp_valid", rsp_valid, 2'b00);
      chk("bp_release_grant", req_ready, 2'b01);
      req_valid = 2'b00;
      rsp_ready = 2'b11;

      // Reset during EXEC of a port-0 op: nothing emitted, tie goes back to port 0.
      do_reset();
      @(negedge clk);
      set_port(0, 32'd1, 32'd1, 4'b0010);
      set_port(1, 32'd2, 32'd2, 4'b0010);
      req_valid = 2'b01;
      #1;
      chk("mr_accept", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      reset     = 1'b1;
      #1;
      chk("mr_in_exec", busy, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mr_busy", busy, 1'b0);
      chk("mr_rsp_valid", rsp_valid, 2'b00);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("mr%0d_no_rsp", c), rsp_valid, 2'b00);
      end
      req_valid = 2'b11;
      #1;
      chk("mr_tie_port0", req_ready, 2'b01);
      req_valid = 2'b00;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
